// File: rtl/csc_channel_scheduler.sv
// Round-robin sharing of one in-order datapath between sample channels,
// with result routing by tag and drain-before-commit parameter gating.
module csc_channel_scheduler #(
    parameter int VOL_MSB      = 14,
    parameter int NUM_CH       = 4,
    parameter int CH_W         = 2,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic [NUM_CH*(VOL_MSB+1)-1:0] ch_data,
    input  logic [NUM_CH-1:0]            ch_en,
    input  logic [NUM_CH-1:0]            ovf_clr,
    output logic [NUM_CH-1:0]            ch_ovf,
    output logic [VOL_MSB:0]             dp_data,
    output logic                         dp_data_en,
    input  logic [VOL_MSB:0]             dp_result,
    input  logic                         dp_result_en,
    output logic [VOL_MSB:0]             out_data,
    output logic                         out_en,
    output logic [CH_W-1:0]              out_ch,
    input  logic                         param_en_in,
    output logic                         dp_param_en,
    output logic                         busy,
    output logic                         err_unexpected
);

    localparam int DW = VOL_MSB + 1;
    localparam int PW = $clog2(MAX_INFLIGHT);
    localparam logic [PW:0] MAX_CNT = (PW+1)'(MAX_INFLIGHT);

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        COMMIT
    } state_t;

    state_t state, state_nxt;

    logic [DW-1:0]     hold [NUM_CH];
    logic [NUM_CH-1:0] pend;
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   tag_mem [MAX_INFLIGHT];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW:0]       inflight;
    logic              param_req;

    logic              gnt_vld;
    logic [CH_W-1:0]   gnt_ch;
    logic [CH_W-1:0]   cand;
    logic              can_issue;
    logic              push;
    logic              pop;
    logic [NUM_CH-1:0] issue_oh;
    logic [NUM_CH-1:0] ovf_set;

    function automatic logic [CH_W-1:0] wrap(input int v);
        return (v >= NUM_CH) ? CH_W'(v - NUM_CH) : CH_W'(v);
    endfunction

    // First pending channel at or after the RR pointer, wrapping
    always_comb begin
        gnt_vld = 1'b0;
        gnt_ch  = '0;
        cand    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = wrap(int'(rr_ptr) + k);
            if (!gnt_vld && pend[cand]) begin
                gnt_vld = 1'b1;
                gnt_ch  = cand;
            end
        end
    end

    assign can_issue = (state == RUN) && !param_req && (inflight < MAX_CNT);
    assign push      = can_issue && gnt_vld;
    assign pop       = dp_result_en && (inflight != '0);
    assign issue_oh  = push ? (NUM_CH'(1) << gnt_ch) : '0;
    assign ovf_set   = ch_en & pend & ~issue_oh;

    always_comb begin
        state_nxt   = state;
        dp_param_en = 1'b0;
        busy        = 1'b1;
        unique case (state)
            RUN: begin
                busy = 1'b0;
                if (param_req) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (inflight == '0 && !dp_data_en) state_nxt = COMMIT;
            end
            COMMIT: begin
                dp_param_en = 1'b1;
                state_nxt   = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= RUN;
            param_req <= 1'b0;
        end else begin
            state     <= state_nxt;
            param_req <= param_en_in | (param_req && state != COMMIT);
        end
    end

    // A same-cycle grant issues the old value, so it is not an overflow
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pend   <= '0;
            ch_ovf <= '0;
            for (int i = 0; i < NUM_CH; i++) hold[i] <= '0;
        end else begin
            pend   <= (pend & ~issue_oh) | ch_en;
            ch_ovf <= (ch_ovf & ~ovf_clr) | ovf_set;
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_en[i]) hold[i] <= ch_data[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            dp_data    <= '0;
            dp_data_en <= 1'b0;
            rr_ptr     <= '0;
        end else begin
            dp_data_en <= push;
            if (push) begin
                dp_data <= hold[gnt_ch];
                rr_ptr  <= wrap(int'(gnt_ch) + 1);
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (push) tag_mem[wr_ptr] <= gnt_ch;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            inflight <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            unique case ({push, pop})
                2'b10:   inflight <= inflight + (PW+1)'(1);
                2'b01:   inflight <= inflight - (PW+1)'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_data       <= '0;
            out_en         <= 1'b0;
            out_ch         <= '0;
            err_unexpected <= 1'b0;
        end else begin
            out_en <= pop;
            if (pop) begin
                out_data <= dp_result;
                out_ch   <= tag_mem[rd_ptr];
            end
            if (dp_result_en && inflight == '0) err_unexpected <= 1'b1;
        end
    end

endmodule
